// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer for the 10-step PWM generator: arbitrates host ramp
// commands against inc/dec button steps and only updates duty on period_end.
module pwm_duty_sequencer #(
   parameter int DUTY_W    = 4,
   parameter int DUTY_MAX  = 10,
   parameter int DUTY_INIT = 5,
   parameter int RATE_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              period_end,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DUTY_W-1:0] cmd_target,
   input  logic [RATE_W-1:0] cmd_rate,
   input  logic              btn_inc,
   input  logic              btn_dec,
   output logic [DUTY_W-1:0] duty_cfg,
   output logic              busy,
   output logic              done
);

   typedef enum logic {ST_IDLE = 1'b0, ST_RAMP = 1'b1} state_t;
   typedef enum logic [1:0] {PEND_NONE = 2'd0, PEND_INC = 2'd1, PEND_DEC = 2'd2} pend_t;

   localparam logic [DUTY_W-1:0] DMAX  = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] DINIT = DUTY_W'(DUTY_INIT);
   localparam logic [DUTY_W-1:0] DONE1 = {{(DUTY_W-1){1'b0}}, 1'b1};
   localparam logic [RATE_W-1:0] RONE  = {{(RATE_W-1){1'b0}}, 1'b1};

   state_t            state_r;
   pend_t             pend_r;
   logic [DUTY_W-1:0] duty_r;
   logic [DUTY_W-1:0] target_r;
   logic [RATE_W-1:0] rate_r;
   logic [RATE_W-1:0] pcnt_r;
   logic              busy_r;
   logic              done_r;

   logic [DUTY_W-1:0] clamp_target_s;
   logic [DUTY_W-1:0] inc_sat_s;
   logic [DUTY_W-1:0] dec_sat_s;
   logic [DUTY_W-1:0] step_s;

   // Saturating duty arithmetic shared by command, ramp and button paths
   always_comb begin
      clamp_target_s = cmd_target;
      inc_sat_s      = duty_r;
      dec_sat_s      = duty_r;
      step_s         = duty_r;
      if (cmd_target > DMAX) begin
         clamp_target_s = DMAX;
      end else begin
         clamp_target_s = cmd_target;
      end
      if (duty_r < DMAX) begin
         inc_sat_s = duty_r + DONE1;
      end else begin
         inc_sat_s = DMAX;
      end
      if (duty_r != {DUTY_W{1'b0}}) begin
         dec_sat_s = duty_r - DONE1;
      end else begin
         dec_sat_s = {DUTY_W{1'b0}};
      end
      if (target_r > duty_r) begin
         step_s = inc_sat_s;
      end else begin
         step_s = dec_sat_s;
      end
   end

   // Sequencer state machine; everything freezes while ena is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         pend_r   <= PEND_NONE;
         duty_r   <= DINIT;
         target_r <= DINIT;
         rate_r   <= {RATE_W{1'b0}};
         pcnt_r   <= {RATE_W{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else if (ena) begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  target_r <= clamp_target_s;
                  rate_r   <= cmd_rate;
                  pcnt_r   <= {RATE_W{1'b0}};
                  pend_r   <= PEND_NONE;
                  if (clamp_target_s == duty_r) begin
                     done_r <= 1'b1;
                  end else begin
                     state_r <= ST_RAMP;
                     busy_r  <= 1'b1;
                  end
               end else begin
                  if (period_end) begin
                     pend_r <= PEND_NONE;
                     if (pend_r == PEND_INC) begin
                        duty_r   <= inc_sat_s;
                        target_r <= inc_sat_s;
                     end else if (pend_r == PEND_DEC) begin
                        duty_r   <= dec_sat_s;
                        target_r <= dec_sat_s;
                     end
                  end
                  // A press on the boundary cycle is queued for the next boundary
                  if (btn_inc && !btn_dec) begin
                     pend_r <= PEND_INC;
                  end else if (btn_dec && !btn_inc) begin
                     pend_r <= PEND_DEC;
                  end
               end
            end
            ST_RAMP: begin
               if (period_end) begin
                  if (rate_r == {RATE_W{1'b0}}) begin
                     duty_r  <= target_r;
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else if (pcnt_r == rate_r - RONE) begin
                     duty_r <= step_s;
                     pcnt_r <= {RATE_W{1'b0}};
                     if (step_s == target_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                     end
                  end else begin
                     pcnt_r <= pcnt_r + RONE;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = ena & (state_r == ST_IDLE);
   assign duty_cfg  = duty_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: directed vector table, hand-written ena/reset
// sequences, then random traffic compared against a behavioural model.
module tb_pwm_duty_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       period_end;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_target;
   logic [7:0] cmd_rate;
   logic       btn_inc;
   logic       btn_dec;
   logic [3:0] duty_cfg;
   logic       busy;
   logic       done;

   int tests = 0;
   int fails = 0;

   pwm_duty_sequencer dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .period_end(period_end),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
      .cmd_rate(cmd_rate), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .duty_cfg(duty_cfg), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ena, pe, cv;
      logic [3:0] tgt;
      logic [7:0] rate;
      logic       inc, dec;
      logic [3:0] e_duty;
      logic       e_busy, e_done;
   } vec_t;

   vec_t tbl[32];

   // behavioural model: integer duty, target, periods counted toward the next step
   int m_duty, m_target, m_rate, m_cnt, m_pend;
   bit m_ramp, m_done;

   function automatic vec_t mk(input logic e, pe, cv, input int t, r, input logic i, d,
                               input int ed, input logic eb, edn);
      vec_t v;
      v.ena = e; v.pe = pe; v.cv = cv; v.tgt = 4'(t); v.rate = 8'(r);
      v.inc = i; v.dec = d; v.e_duty = 4'(ed); v.e_busy = eb; v.e_done = edn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_init();
      m_duty = 5; m_target = 5; m_rate = 0; m_cnt = 0; m_pend = 0;
      m_ramp = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_step(input bit e, pe, cv, input int t, r, input bit i, d);
      bit nd;
      int tc;
      if (!e) return;
      nd = 1'b0;
      if (!m_ramp) begin
         if (cv) begin
            tc = (t > 10) ? 10 : t;
            m_target = tc; m_rate = r; m_cnt = 0; m_pend = 0;
            if (tc == m_duty) nd = 1'b1;
            else m_ramp = 1'b1;
         end else begin
            if (pe && m_pend == 1) m_duty = (m_duty + 1 > 10) ? 10 : m_duty + 1;
            if (pe && m_pend == 2) m_duty = (m_duty - 1 < 0) ? 0 : m_duty - 1;
            if (pe && m_pend != 0) m_target = m_duty;
            if (pe) m_pend = 0;
            if (i && !d) m_pend = 1;
            else if (d && !i) m_pend = 2;
         end
      end else if (pe) begin
         if (m_rate == 0) begin
            m_duty = m_target;
         end else begin
            m_cnt++;
            if (m_cnt == m_rate) begin
               m_cnt = 0;
               m_duty += (m_target > m_duty) ? 1 : -1;
            end
         end
         if (m_duty == m_target) begin
            m_ramp = 1'b0;
            nd = 1'b1;
         end
      end
      m_done = nd;
   endtask

   task automatic drive(input logic e, pe, cv, input logic [3:0] t, input logic [7:0] r,
                        input logic i, d);
      ena = e; period_end = pe; cmd_valid = cv; cmd_target = t; cmd_rate = r;
      btn_inc = i; btn_dec = d;
   endtask

   initial begin
      logic prev_busy;
      logic e, pe, cv, bi, bd;
      logic [3:0] t;
      logic [7:0] r;

      //          ena pe cv tgt rate inc dec  duty busy done
      tbl[0]  = mk(1, 0, 1,  8, 2,   0,  0,   5,   1,   0);
      tbl[1]  = mk(1, 1, 0,  0, 0,   0,  0,   5,   1,   0);
      tbl[2]  = mk(1, 0, 0,  0, 0,   0,  0,   5,   1,   0);
      tbl[3]  = mk(1, 1, 0,  0, 0,   0,  0,   6,   1,   0);
      tbl[4]  = mk(1, 1, 0,  0, 0,   0,  0,   6,   1,   0);
      tbl[5]  = mk(1, 1, 0,  0, 0,   0,  0,   7,   1,   0);
      tbl[6]  = mk(1, 1, 0,  0, 0,   0,  0,   7,   1,   0);
      tbl[7]  = mk(1, 1, 0,  0, 0,   0,  0,   8,   0,   1);
      tbl[8]  = mk(1, 0, 0,  0, 0,   0,  0,   8,   0,   0);
      tbl[9]  = mk(1, 0, 1, 15, 0,   0,  0,   8,   1,   0);
      tbl[10] = mk(1, 1, 0,  0, 0,   0,  0,  10,   0,   1);
      tbl[11] = mk(1, 0, 1, 10, 3,   0,  0,  10,   0,   1);
      tbl[12] = mk(1, 0, 0,  0, 0,   0,  0,  10,   0,   0);
      tbl[13] = mk(1, 0, 0,  0, 0,   1,  0,  10,   0,   0);
      tbl[14] = mk(1, 1, 0,  0, 0,   0,  0,  10,   0,   0);
      tbl[15] = mk(1, 0, 0,  0, 0,   1,  0,  10,   0,   0);
      tbl[16] = mk(1, 0, 0,  0, 0,   0,  1,  10,   0,   0);
      tbl[17] = mk(1, 1, 0,  0, 0,   0,  0,   9,   0,   0);
      tbl[18] = mk(1, 0, 0,  0, 0,   1,  1,   9,   0,   0);
      tbl[19] = mk(1, 1, 0,  0, 0,   0,  0,   9,   0,   0);
      tbl[20] = mk(1, 0, 1,  0, 0,   0,  0,   9,   1,   0);
      tbl[21] = mk(1, 1, 0,  0, 0,   0,  0,   0,   0,   1);
      tbl[22] = mk(1, 0, 0,  0, 0,   0,  1,   0,   0,   0);
      tbl[23] = mk(1, 1, 0,  0, 0,   0,  0,   0,   0,   0);
      tbl[24] = mk(1, 0, 1,  5, 0,   0,  0,   0,   1,   0);
      tbl[25] = mk(1, 1, 0,  0, 0,   0,  0,   5,   0,   1);
      tbl[26] = mk(1, 0, 1,  7, 1,   0,  1,   5,   1,   0);
      tbl[27] = mk(1, 1, 0,  0, 0,   0,  0,   6,   1,   0);
      tbl[28] = mk(1, 1, 0,  0, 0,   0,  0,   7,   0,   1);
      tbl[29] = mk(1, 1, 0,  0, 0,   1,  0,   7,   0,   0);
      tbl[30] = mk(1, 1, 0,  0, 0,   0,  0,   8,   0,   0);
      tbl[31] = mk(1, 0, 0,  0, 0,   0,  0,   8,   0,   0);

      rst_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_duty", duty_cfg, 5);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_ready", cmd_ready, 1);

      // directed table
      prev_busy = 1'b0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         drive(tbl[k].ena, tbl[k].pe, tbl[k].cv, tbl[k].tgt, tbl[k].rate, tbl[k].inc, tbl[k].dec);
         #1 chk($sformatf("tbl%0d_ready", k), cmd_ready, tbl[k].ena & ~prev_busy);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_duty", k), duty_cfg, tbl[k].e_duty);
         chk($sformatf("tbl%0d_busy", k), busy, tbl[k].e_busy);
         chk($sformatf("tbl%0d_done", k), done, tbl[k].e_done);
         prev_busy = tbl[k].e_busy;
      end

      // ena freeze mid-ramp: 8 -> 2 at rate 3, two periods counted before freeze
      @(negedge clk); drive(1'b1, 1'b0, 1'b1, 4'd2, 8'd3, 1'b0, 1'b0);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); drive(1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
         #1 chk("frz_ready", cmd_ready, 0);
         @(negedge clk); drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
         chk("frz_duty", duty_cfg, 8);
      end
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("resume_duty", duty_cfg, 7);
      chk("resume_busy", busy, 1);

      // asynchronous reset mid-ramp, away from any clock edge
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_duty", duty_cfg, 5);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_ready", cmd_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      model_init();

      // random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         e  = ($urandom_range(0, 9) != 0);
         pe = ($urandom_range(0, 3) == 0);
         cv = ($urandom_range(0, 9) == 0);
         t  = 4'($urandom_range(0, 15));
         r  = 8'($urandom_range(0, 3));
         bi = ($urandom_range(0, 7) == 0);
         bd = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         drive(e, pe, cv, t, r, bi, bd);
         #1 chk("rnd_ready", cmd_ready, e & ~m_ramp);
         model_step(e, pe, cv, int'(t), int'(r), bi, bd);
         @(posedge clk); #1;
         chk("rnd_duty", duty_cfg, m_duty);
         chk("rnd_busy", busy, m_ramp);
         chk("rnd_done", done, m_done);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Controller that configures the duty-cycle input of the 10-step PWM generator.
- Arbitrates two requesters for that one duty setting:
  - a host command port (valid/ready), which ramps duty to a target at a programmable rate;
  - debounced inc/dec button pulses, which give ±1 steps.
- Applies every duty change only at a PWM period boundary, so no output period is ever truncated or glitched.

Parameters:
- DUTY_W, 4: width of duty values.
- DUTY_MAX, 10: maximum duty step (100 %). Targets above it are clamped.
- DUTY_INIT, 5: duty after reset (50 %).
- RATE_W, 8: width of the ramp-rate field, in PWM periods per step.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; one clock domain.
- ena  in  1  block enable. When 0, all state holds.
- period_end  in  1  one-cycle pulse from the PWM generator on the last count of each PWM period.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready are high at a clk edge.
- cmd_target  in  DUTY_W  requested final duty.
- cmd_rate  in  RATE_W  PWM periods per ±1 step; 0 = jump straight to target.
- btn_inc  in  1  debounced one-cycle increment pulse.
- btn_dec  in  1  debounced one-cycle decrement pulse.
- duty_cfg  out  DUTY_W  registered duty value driven to the PWM generator.
- busy  out  1  high while a ramp is in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (asynchronous, any time, including mid-ramp):
  - state=IDLE, duty_cfg=DUTY_INIT, target=DUTY_INIT, pcnt=0;
  - busy=0, done=0, cmd_ready=1 (cmd_ready returns to 1 once ena=1);
  - pending button flags cleared.
- ena=0: all registers hold, cmd_ready forced 0, period_end/btn_inc/btn_dec ignored. Pulses arriving then are lost.
- cmd_ready = ena & (state==IDLE).
- Command accept (IDLE):
  - target := min(cmd_target, DUTY_MAX); rate := cmd_rate; pcnt := 0; pending buttons cleared.
  - If the clamped target equals duty_cfg: stay IDLE; done=1 on the next cycle; duty_cfg unchanged.
  - Otherwise: next state RAMP, busy=1 from the next cycle.
- RAMP, on each period_end:
  - If rate==0: duty_cfg := target.
  - Else if pcnt==rate-1: duty_cfg := duty_cfg±1 toward target, pcnt := 0.
  - Else: pcnt := pcnt+1.
  - When the newly registered duty_cfg equals target, in the same edge: state := IDLE, busy := 0, done := 1 for exactly one cycle.
- Sub-boundary timing: duty_cfg changes only on the edge where period_end=1, so the new value is seen from the next period's first count.
- In RAMP: cmd_valid is stalled (cmd_ready=0); btn_inc/btn_dec are dropped.
- Buttons in IDLE:
  - btn_inc sets pend=INC; btn_dec sets pend=DEC. A later press overwrites an earlier one (last wins).
  - btn_inc & btn_dec in the same cycle: both ignored, existing pend kept.
  - On period_end with pend=INC: duty_cfg := min(duty_cfg+1, DUTY_MAX). With pend=DEC: duty_cfg := duty_cfg-1, saturating at 0. In both cases target := new duty_cfg and pend is cleared.
  - Button steps never pulse done or busy.
  - A button press in the same cycle as period_end is registered as pending and applies at the following period_end.
- Arbitration, same cycle in IDLE: an accepted command wins and any button pulse that cycle is dropped.
- Widths:
  - All duty arithmetic is in DUTY_W bits with saturation; no wrap-around at 0 or DUTY_MAX.
  - pcnt is RATE_W bits and never exceeds rate-1.

Test Plan:
- Reset, ena=1, no input -> duty_cfg=5, busy=0, cmd_ready=1, done=0; assert rst_n low mid-ramp -> outputs back to reset values immediately, without waiting for a clk edge.
- cmd_target=8, cmd_rate=2 from duty 5 -> duty_cfg 6,7,8 at the 2nd, 4th and 6th period_end after accept; busy high throughout; done one cycle with duty_cfg=8; cmd_ready low until IDLE.
- cmd_target=15 (clamp), cmd_rate=0 -> duty_cfg=10 at the first period_end; done pulse; then cmd_target=10 -> no ramp, done next cycle, duty_cfg stays 10.
- IDLE at duty 10: btn_inc -> stays 10. At duty 0: btn_dec -> stays 0. btn_inc then btn_dec before period_end -> duty decrements by 1 at period_end (last press wins). btn_inc & btn_dec in the same cycle -> no change.
- cmd_valid and btn_dec in the same cycle at duty 5, target 7, rate 1 -> command wins, btn_dec dropped; duty 6 at the 1st period_end, 7 at the 2nd.
- During a ramp drop ena to 0 for 5 period_end pulses -> duty_cfg and pcnt frozen, cmd_ready=0; re-enable -> ramp resumes from the frozen pcnt.
